fnd_dot_blinker: RTL



---
 rtl/fnd_dot_blinker.sv | 69 ++++++
 1 files changed

// File: rtl/fnd_dot_blinker.sv
// Decimal-point blinker for the FND digit mux: sub-second phase counter plus per-digit active-low dot decode.
// Latency: one clk from tick/sync/mode/mask to registered outputs; no backpressure (tick-driven, never stalls).
module fnd_dot_blinker #(
  parameter int DIGITS          = 4,
  parameter int TICK_PER_PERIOD = 100,
  parameter int ON_START        = 50,
  parameter int PW              = $clog2(TICK_PER_PERIOD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_tick,
  input  logic              i_run,
  input  logic              i_sync,
  input  logic [1:0]        i_mode,
  input  logic [DIGITS-1:0] i_mask,
  output logic [DIGITS-1:0] o_dot,
  output logic [PW-1:0]     o_phase,
  output logic              o_wrap
);

  localparam logic [PW-1:0] LAST_PHASE = PW'(TICK_PER_PERIOD - 1);
  localparam logic [PW-1:0] ON_PHASE   = PW'(ON_START);

  logic [PW-1:0]     phase_next;
  logic              wrap_next;
  logic              lit;
  logic [DIGITS-1:0] dot_next;

  // Wrap is detected by explicit compare against the last phase, never by overflow.
  always_comb begin
    phase_next = o_phase;
    wrap_next  = 1'b0;
    if (i_sync) begin
      phase_next = '0;
    end else if (i_tick && i_run) begin
      if (o_phase == LAST_PHASE) begin
        phase_next = '0;
        wrap_next  = 1'b1;
      end else begin
        phase_next = o_phase + PW'(1);
      end
    end
  end

  // Decode from phase_next so the registered dots line up with the registered phase.
  always_comb begin
    lit = 1'b0;
    case (i_mode)
      2'b00:   lit = 1'b0;
      2'b01:   lit = 1'b1;
      2'b10:   lit = (phase_next >= ON_PHASE);
      default: lit = (phase_next <  ON_PHASE);
    endcase
    dot_next = ~({DIGITS{lit}} & i_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_phase <= '0;
      o_wrap  <= 1'b0;
      o_dot   <= '1;
    end else begin
      o_phase <= phase_next;
      o_wrap  <= wrap_next;
      o_dot   <= dot_next;
    end
  end

endmodule
